// File: rtl/time_of_day.sv
// -----------------------------------------------------------------------------
// time_of_day
//
// 24-hour time-of-day counter. A prescaler divides clk down to a 1 s tick that
// advances seconds/minutes/hours. A one-cycle clock_carry pulse marks every
// 23:59:59 -> 00:00:00 rollover and feeds the day increment of the calendar
// block. In set mode counting is frozen, and push-button rising edges step
// each field on its own. Six active-low 7-segment digits mirror the time.
//
// Parameters
//   TICK_DIV     clk cycles per one-second tick (minimum 2)
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   reset        synchronous, active-high; clears all state
//   up[2:0]      asynchronous button levels: [0] second, [1] minute, [2] hour
//   set          1 = set mode (counting frozen), 0 = run mode
//   time_count   [5:0] seconds, [11:6] minutes, [16:12] hours (binary)
//   clock_carry  one-cycle pulse on day rollover (run mode only)
//   time_7seg    six active-low digits, bit0 = a .. bit6 = g:
//                [6:0] sec ones, [13:7] sec tens, [20:14] min ones,
//                [27:21] min tens, [34:28] hr ones, [41:35] hr tens
// -----------------------------------------------------------------------------
module time_of_day #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  up,
    input  logic        set,
    output logic [16:0] time_count,
    output logic        clock_carry,
    output logic [41:0] time_7seg
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int              PS_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [4:0] HR_MAX  = 5'd23;

    // -------------------------------------------------------------------------
    // Prescaler: counts 0..TICK_DIV-1. tick is high in the last count.
    // In set mode it is parked at 0. After leaving set mode, the first tick
    // therefore arrives a full TICK_DIV cycles later.
    // -------------------------------------------------------------------------
    logic [PS_W-1:0] prescaler;
    logic            tick;

    assign tick = (prescaler == PS_LAST);

    // NOTE: state registers use non-blocking (<=) assignments, so every
    // always_ff samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
        end else if (set || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PS_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Button conditioning: a 2-flop synchronizer per bit, followed by an edge
    // register. A held button produces one rise only. The button has to be
    // sampled low again before it can produce another rise.
    // -------------------------------------------------------------------------
    logic [2:0] up_meta;
    logic [2:0] up_sync;
    logic [2:0] up_prev;
    logic [2:0] up_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            up_meta <= '0;
            up_sync <= '0;
            up_prev <= '0;
        end else begin
            up_meta <= up;
            up_sync <= up_meta;
            up_prev <= up_sync;
        end
    end

    assign up_rise = up_sync & ~up_prev;

    // -------------------------------------------------------------------------
    // Time fields
    // -------------------------------------------------------------------------
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;

    // Single-field increments with wrap. In set mode there is no carry into
    // the next field, so each field uses these on its own.
    function automatic logic [5:0] inc_sixty(input logic [5:0] v);
        return (v == SEC_MAX) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_hours(input logic [4:0] v);
        return (v == HR_MAX) ? 5'd0 : v + 5'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            sec         <= '0;
            min         <= '0;
            hr          <= '0;
            clock_carry <= 1'b0;
        end else begin
            // Defaults to low, so the carry is a single-cycle pulse.
            clock_carry <= 1'b0;

            if (set) begin
                // Set mode takes priority over a tick that falls in the
                // same cycle. Several buttons may step their fields together.
                if (up_rise[0]) sec <= inc_sixty(sec);
                if (up_rise[1]) min <= inc_sixty(min);
                if (up_rise[2]) hr  <= inc_hours(hr);
            end else if (tick) begin
                // Run mode: ripple the carry through seconds, minutes, hours.
                // Button rises are ignored here.
                sec <= inc_sixty(sec);
                if (sec == SEC_MAX) begin
                    min <= inc_sixty(min);
                    if (min == MIN_MAX) begin
                        hr <= inc_hours(hr);
                        if (hr == HR_MAX) begin
                            clock_carry <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign time_count = {hr, min, sec};

    // -------------------------------------------------------------------------
    // 7-segment display, combinational from the registered fields.
    // -------------------------------------------------------------------------
    function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
        logic [6:0] glyph;
        // NOTE: the default arm assigns the result on every path. Without
        // it, a combinational decode could infer a latch.
        case (digit)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase
        return glyph;
    endfunction

    // Field values are always in range, so every quotient and remainder
    // fits in one BCD digit.
    logic [3:0] sec_ones, sec_tens;
    logic [3:0] min_ones, min_tens;
    logic [3:0] hr_ones,  hr_tens;

    assign sec_tens = 4'(sec / 6'd10);
    assign sec_ones = 4'(sec % 6'd10);
    assign min_tens = 4'(min / 6'd10);
    assign min_ones = 4'(min % 6'd10);
    assign hr_tens  = 4'(hr / 5'd10);
    assign hr_ones  = 4'(hr % 5'd10);

    assign time_7seg = {seg_glyph(hr_tens),  seg_glyph(hr_ones),
                        seg_glyph(min_tens), seg_glyph(min_ones),
                        seg_glyph(sec_tens), seg_glyph(sec_ones)};

endmodule

// File: tb/tb_time_of_day.sv
// -----------------------------------------------------------------------------
// tb_time_of_day
//
// Self-checking bench for time_of_day with TICK_DIV = 4. A behavioural model
// holds the time as seconds-of-day plus a history of sampled button levels.
// A compare process checks every DUT output after every clock edge. Directed
// scenarios add literal expectations, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_time_of_day;

    localparam int TD = 4;

    logic        clk;
    logic        reset;
    logic [2:0]  up;
    logic        set;
    logic [16:0] time_count;
    logic        clock_carry;
    logic [41:0] time_7seg;

    int n_checks = 0;
    int n_pass   = 0;

    time_of_day #(.TICK_DIV(TD)) dut (
        .clk         (clk),
        .reset       (reset),
        .up          (up),
        .set         (set),
        .time_count  (time_count),
        .clock_carry (clock_carry),
        .time_7seg   (time_7seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [16:0] tc(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [41:0] seg_of(input int h, input int m, input int s);
        return {glyph(h / 10), glyph(h % 10), glyph(m / 10), glyph(m % 10),
                glyph(s / 10), glyph(s % 10)};
    endfunction

    localparam logic [41:0] SEG_ZERO   = {6{7'b1000000}};
    localparam logic [41:0] SEG_123456 = {7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010};

    // -------------------------------------------------------------------------
    // Behavioural model: time is seconds-of-day. Button rise at edge t means
    // up was sampled high at edge t-2 and low at edge t-3.
    // -------------------------------------------------------------------------
    int       m_sod   = 0;
    bit       m_carry = 1'b0;
    int       m_phase = 0;
    bit [2:0] h1 = '0, h2 = '0, h3 = '0;
    bit [2:0] m_rise;
    bit       m_valid = 1'b0;
    int       mh, mm, ms;

    always @(posedge clk) begin
        if (reset) begin
            m_sod   = 0;
            m_carry = 1'b0;
            m_phase = 0;
            h1 = '0; h2 = '0; h3 = '0;
            m_valid = 1'b1;
        end else begin
            m_rise  = h2 & ~h3;
            m_carry = 1'b0;
            if (set) begin
                m_phase = 0;
                mh = m_sod / 3600;
                mm = (m_sod / 60) % 60;
                ms = m_sod % 60;
                if (m_rise[0]) ms = (ms + 1) % 60;
                if (m_rise[1]) mm = (mm + 1) % 60;
                if (m_rise[2]) mh = (mh + 1) % 24;
                m_sod = mh * 3600 + mm * 60 + ms;
            end else if (m_phase == TD - 1) begin
                m_phase = 0;
                m_sod   = (m_sod + 1) % 86400;
                m_carry = (m_sod == 0);
            end else begin
                m_phase++;
            end
            h3 = h2; h2 = h1; h1 = up;
        end
    end

    // Compare process: checks every output just after every rising edge.
    always begin
        @(posedge clk);
        #1;
        if (m_valid) begin
            check("time_count", time_count, tc(m_sod / 3600, (m_sod / 60) % 60, m_sod % 60));
            check("clock_carry", clock_carry, m_carry);
            check("time_7seg", time_7seg, seg_of(m_sod / 3600, (m_sod / 60) % 60, m_sod % 60));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus (inputs change on the falling edge)
    // -------------------------------------------------------------------------
    task automatic pulse(input logic [2:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            up = mask;
            repeat (2) @(negedge clk);
            up = 3'b000;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int       hold = 0;
    bit [2:0] up_r = '0;

    initial begin
        reset = 1'b1;
        set   = 1'b0;
        up    = 3'b000;

        // Reset held for two edges, then one more edge with reset still high.
        repeat (2) @(negedge clk);
        check("reset_tc", time_count, 17'd0);
        check("reset_carry", clock_carry, 1'b0);
        check("reset_seg", time_7seg, SEG_ZERO);
        @(negedge clk);
        check("reset_hold_tc", time_count, 17'd0);
        reset = 1'b0;

        // Set-mode increments.
        set = 1'b1;
        pulse(3'b100, 25);
        check("hr_wrap", time_count, tc(1, 0, 0));
        up = 3'b010;
        repeat (100) @(negedge clk);
        up = 3'b000;
        repeat (3) @(negedge clk);
        check("min_hold_once", time_count, tc(1, 1, 0));
        pulse(3'b001, 60);
        check("sec_wrap", time_count, tc(1, 1, 0));

        // Run and rollover from 23:59:58.
        do_reset();
        pulse(3'b111, 23);
        pulse(3'b011, 36);
        pulse(3'b001, 59);
        check("preset_235958", time_count, tc(23, 59, 58));
        set = 1'b0;
        repeat (3) @(negedge clk);
        check("no_tick_yet", time_count, tc(23, 59, 58));
        @(negedge clk);
        check("tick_235959", time_count, tc(23, 59, 59));
        check("tick_235959_carry", clock_carry, 1'b0);
        repeat (4) @(negedge clk);
        check("rollover_tc", time_count, 17'd0);
        check("rollover_carry", clock_carry, 1'b1);
        check("rollover_seg", time_7seg, SEG_ZERO);
        @(negedge clk);
        check("carry_one_cycle", clock_carry, 1'b0);
        repeat (3) @(negedge clk);
        check("tick_000001", time_count, tc(0, 0, 1));
        check("tick_000001_carry", clock_carry, 1'b0);

        // Run mode ignores buttons.
        pulse(3'b111, 1);
        check("run_ignores_up", time_count, tc(0, 0, 2));

        // Set raised in the tick cycle wins.
        repeat (3) @(negedge clk);
        set = 1'b1;
        @(negedge clk);
        check("collision_no_inc", time_count, tc(0, 0, 2));
        @(negedge clk);
        set = 1'b0;
        repeat (3) @(negedge clk);
        check("resume_no_tick_yet", time_count, tc(0, 0, 2));
        @(negedge clk);
        check("resume_tick", time_count, tc(0, 0, 3));

        // Reset mid-count at 12:34:56 with the prescaler at its last count.
        set = 1'b1;
        do_reset();
        pulse(3'b111, 12);
        pulse(3'b011, 22);
        pulse(3'b001, 22);
        check("preset_123456", time_count, tc(12, 34, 56));
        check("seg_123456", time_7seg, SEG_123456);
        set = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_seg", time_7seg, SEG_123456);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_tc", time_count, 17'd0);
        check("mid_reset_carry", clock_carry, 1'b0);
        check("mid_reset_seg", time_7seg, SEG_ZERO);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_no_tick", time_count, 17'd0);
        @(negedge clk);
        check("post_reset_tick", time_count, tc(0, 0, 1));

        // Randomized phase, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                up_r = 3'($urandom_range(0, 7));
                hold = $urandom_range(1, 6);
            end
            hold--;
            up = up_r;
            if ($urandom_range(0, 39) == 0) set = ~set;
            reset = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        up    = 3'b000;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/time_of_day.md
# time_of_day

Time-of-day counter that sits directly upstream of the calendar `date` block. It divides the system clock into a 1 s tick and keeps hours, minutes and seconds in 24-hour format. It emits `clock_carry`, a one-cycle pulse on each 23:59:59 -> 00:00:00 rollover, which drives the `date` block's day increment. It also supports manual time setting from push-buttons and drives six 7-segment digits.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per second tick. Minimum 2.
- `clk`  input  1  system clock, all state on rising edge.
- `reset`  input  1  synchronous, active-high; clears all state.
- `up`  input  3  increment requests, level, active-high, asynchronous to clk: [0] second, [1] minute, [2] hour.
- `set`  input  1  1 = set mode (counting frozen), 0 = run mode.
- `time_count`  output  17  [5:0] seconds 0-59, [11:6] minutes 0-59, [16:12] hours 0-23, binary.
- `clock_carry`  output  1  one-clk-cycle pulse on day rollover in run mode.
- `time_7seg`  output  42  six digits, 7 bits each, active-low, bit0 = a ... bit6 = g. Digit order: [6:0] sec ones, [13:7] sec tens, [20:14] min ones, [27:21] min tens, [34:28] hr ones, [41:35] hr tens.

## Operation
- Prescaler: counter 0..TICK_DIV-1, width $clog2(TICK_DIV). The tick is true when the prescaler equals TICK_DIV-1. On a tick the prescaler returns to 0.
- Run mode (`set`=0), on a tick:
  - Seconds increment.
  - At 59, seconds wrap to 0 and minutes increment.
  - At 59, minutes wrap to 0 and hours increment.
  - At 23, hours wrap to 0 and `clock_carry` is set for one cycle.
- Run mode ignores `up` edges. The edge detectors keep tracking, but no increment is applied.
- Set mode (`set`=1):
  - Prescaler is held at 0 and no ticks occur.
  - Each synchronized rising edge of `up[i]` increments its field by 1 with independent wrap: sec 59->0, min 59->0, hr 23->0.
  - No carry into the next field; `clock_carry` is never asserted.
- Leaving set mode: counting resumes from prescaler 0, so the first tick comes TICK_DIV cycles after `set` is sampled low.
- `up` handling: a 2-flop synchronizer per bit, then an edge register. A held button gives exactly one increment; it must be released (sampled low) before the next increment.
- Several `up` bits rising in the same cycle: all addressed fields increment in that cycle.
- A tick in the same cycle that `set` is sampled high: `set` wins and no increment happens.
- `time_7seg`: combinational from `time_count`. Tens = value/10, ones = value%10, standard hex-decoder glyphs for digits 0-9. Leading zeros are shown.
- Reset values:
  - `time_count` = 0 (00:00:00).
  - `clock_carry` = 0.
  - Prescaler = 0.
  - Synchronizer and edge registers = 0.
  - `time_7seg` = six "0" glyphs (each 7'b1000000).
- Reset mid-operation aborts any pending tick or button edge. Reset has priority over everything.

## Timing
- Tick period: exactly TICK_DIV clk cycles in run mode. With reset released at edge R, the first tick-increment lands at edge R+TICK_DIV.
- `clock_carry` is registered. It is high during the single cycle in which `time_count` first reads 0, and low in the next cycle.
- Button latency: `up[i]` first high at edge N gives a field update at edge N+2, visible after it. The level must be stable for at least 2 clk cycles to be seen.
- `time_count` is registered. `time_7seg` has zero additional latency.

## Test plan
- **Reset:** assert `reset` for 2 cycles at arbitrary time -> `time_count`=0, `clock_carry`=0, every 7-bit digit = 7'b1000000. The next edge with reset still high keeps all values at 0.
- **Run and rollover:** TICK_DIV=4; set time to 23:59:58, release `set` -> after 4 cycles 23:59:59; after 8 cycles 00:00:00 with `clock_carry`=1 for exactly one cycle; after 12 cycles 00:00:01 with no carry.
- **Set mode increments:** `set`=1; pulse `up[2]` 25 times -> hours go 0..23 then 1, no `clock_carry`. Hold `up[1]` high for 100 cycles -> minutes +1 only. Pulse `up[0]` 60 times from 0 -> seconds return to 0, minutes unchanged.
- **Run mode ignores buttons:** `set`=0, pulse `up`=3'b111 -> `time_count` changes only on ticks.
- **Set/tick collision:** raise `set` in the cycle the prescaler equals TICK_DIV-1 -> no increment. Drop `set` -> the next increment arrives exactly TICK_DIV cycles later.
- **Reset mid-count:** at 12:34:56 with prescaler at TICK_DIV-1, assert `reset` -> 00:00:00, no tick, no carry. The first tick comes TICK_DIV cycles after release. The 7-seg display reads "123456" before reset and "000000" after.
